// File: rtl/rtc_tick_gen_if.sv
// Increment-update handshake between a register block (master) and rtc_tick_gen (slave).
interface rtc_tick_gen_if #(
  parameter int unsigned ACC_WIDTH = 32
);
  logic                 cfg_valid;
  logic [ACC_WIDTH-1:0] cfg_inc;
  logic                 cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_inc,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_inc,
    output cfg_ready
  );
endinterface

// File: rtl/rtc_tick_gen.sv
// Phase-accumulator RTC square-wave generator: f_rtc = f_clk * inc / 2^ACC_WIDTH,
// retunable at period boundaries, always stopping on a low level.
module rtc_tick_gen #(
  parameter int unsigned ACC_WIDTH   = 32,
  parameter logic [31:0] DEFAULT_INC = 32'd1407,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  rtc_tick_gen_if.slave        cfg,
  output logic                 rtc_o,
  output logic                 rtc_rise_o,
  output logic [CNT_WIDTH-1:0] tick_cnt_o,
  output logic                 busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ACC_WIDTH-1:0] HALF = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [63:0] DEF_WIDE  = 64'(DEFAULT_INC);
  localparam logic [63:0] HALF_WIDE = 64'(HALF);
  localparam logic [ACC_WIDTH-1:0] DEF_INC_C =
    (DEF_WIDE > HALF_WIDE) ? HALF : ACC_WIDTH'(DEFAULT_INC);

  // Limiting inc to half the modulus guarantees each half-period lasts >= 1 cycle.
  function automatic logic [ACC_WIDTH-1:0] clamp_inc(input logic [ACC_WIDTH-1:0] v);
    return (v > HALF) ? HALF : v;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [ACC_WIDTH-1:0] shadow_q;
  logic                 pending_q, pending_d;
  logic                 shadow_ld;
  logic                 rise_q, rise_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 ovf;
  logic                 cfg_take;
  logic [ACC_WIDTH-1:0] inc_clamped;

  assign {ovf, acc_sum} = {1'b0, acc_q} + {1'b0, inc_q};
  assign cfg_take       = cfg.cfg_valid && !pending_q;
  assign inc_clamped    = clamp_inc(cfg.cfg_inc);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    inc_d     = inc_q;
    pending_d = pending_q;
    shadow_ld = 1'b0;

    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        acc_d = acc_sum;
        if (!en_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en_i) begin
          acc_d   = acc_sum;
          state_d = ST_RUN;
        end else if (ovf) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_sum;
        end
      end
      default: begin
        acc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Drain completion is itself a wrap, so one rule covers both retune points.
    if (pending_q && ovf && (state_q != ST_IDLE)) begin
      inc_d     = shadow_q;
      pending_d = 1'b0;
    end

    if (cfg_take) begin
      if (state_q == ST_IDLE) begin
        inc_d = inc_clamped;
      end else begin
        shadow_ld = 1'b1;
        pending_d = 1'b1;
      end
    end
  end

  assign rise_d = !acc_q[ACC_WIDTH-1] && acc_d[ACC_WIDTH-1];

  // Register stage: all architectural state and the registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      inc_q     <= DEF_INC_C;
      pending_q <= 1'b0;
      rise_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      pending_q <= pending_d;
      rise_q    <= rise_d;
      if (rise_d) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (shadow_ld) shadow_q <= inc_clamped;
  end

  assign rtc_o         = acc_q[ACC_WIDTH-1];
  assign rtc_rise_o    = rise_q;
  assign tick_cnt_o    = cnt_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign cfg.cfg_ready = !pending_q;

endmodule

// File: tb/tb_rtc_tick_gen.sv
// Directed bench for rtc_tick_gen at ACC_WIDTH=8, CNT_WIDTH=8.
module tb_rtc_tick_gen;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          rtc;
  logic          rise;
  logic          busy;
  logic [CW-1:0] tick_cnt;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  rtc_tick_gen_if #(.ACC_WIDTH(W)) cfg_if ();

  rtc_tick_gen #(
    .ACC_WIDTH  (W),
    .DEFAULT_INC(32'd1407),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .cfg       (cfg_if),
    .rtc_o     (rtc),
    .rtc_rise_o(rise),
    .tick_cnt_o(tick_cnt),
    .busy_o    (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en  = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic load_inc(input logic [W-1:0] v);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = v;
    tick;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic start_run;
    en = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; cfg_if.cfg_valid = 1'b0; cfg_if.cfg_inc = '0;
    tick; tick;
    checks++; if (dut.acc_q !== 8'd0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", dut.acc_q); end
    checks++; if (rtc !== 1'b0) begin failures++; $display("FAIL reset_rtc got=%b exp=0", rtc); end
    checks++; if (rise !== 1'b0) begin failures++; $display("FAIL reset_rise got=%b exp=0", rise); end
    checks++; if (tick_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", tick_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
    rst = 1'b0;
  endtask

  // Default 1407 clamps to 128 at W=8: rtc toggles every cycle.
  task automatic test_default_inc;
    logic [W-1:0] ea;
    start_run;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dflt_busy got=%b exp=1", busy); end
    checks++; if (dut.acc_q !== 8'd0) begin failures++; $display("FAIL dflt_first_acc got=%0d exp=0", dut.acc_q); end
    for (int i = 0; i < 4; i++) begin
      ea = (i % 2 == 0) ? 8'd128 : 8'd0;
      tick;
      checks++; if (dut.acc_q !== ea) begin failures++; $display("FAIL dflt_acc cyc=%0d got=%0d exp=%0d", i, dut.acc_q, ea); end
      checks++; if (rtc !== ea[7]) begin failures++; $display("FAIL dflt_rtc cyc=%0d got=%b exp=%b", i, rtc, ea[7]); end
    end
    do_reset;
  endtask

  task automatic test_inc64;
    logic [W-1:0] ea;
    do_reset;
    load_inc(8'd64);
    start_run;
    for (int i = 0; i < 40; i++) begin
      ea = 8'((i + 1) * 64);
      tick;
      checks++; if (dut.acc_q !== ea) begin failures++; $display("FAIL inc64_acc cyc=%0d got=%0d exp=%0d", i, dut.acc_q, ea); end
      checks++; if (rtc !== ea[7]) begin failures++; $display("FAIL inc64_rtc cyc=%0d got=%b exp=%b", i, rtc, ea[7]); end
      checks++; if (rise !== (ea == 8'd128)) begin failures++; $display("FAIL inc64_rise cyc=%0d got=%b exp=%b", i, rise, (ea == 8'd128)); end
    end
    checks++; if (tick_cnt !== 8'd10) begin failures++; $display("FAIL inc64_cnt got=%0d exp=10", tick_cnt); end
  endtask

  task automatic test_inc96;
    logic [W-1:0] seq [8];
    logic [W-1:0] prev;
    logic         er;
    seq = '{8'd96, 8'd192, 8'd32, 8'd128, 8'd224, 8'd64, 8'd160, 8'd0};
    prev = 8'd0;
    do_reset;
    load_inc(8'd96);
    start_run;
    for (int i = 0; i < 8; i++) begin
      er = !prev[7] && seq[i][7];
      tick;
      checks++; if (dut.acc_q !== seq[i]) begin failures++; $display("FAIL inc96_acc cyc=%0d got=%0d exp=%0d", i, dut.acc_q, seq[i]); end
      checks++; if (rise !== er) begin failures++; $display("FAIL inc96_rise cyc=%0d got=%b exp=%b", i, rise, er); end
      prev = seq[i];
    end
    checks++; if (tick_cnt !== 8'd3) begin failures++; $display("FAIL inc96_cnt got=%0d exp=3", tick_cnt); end
  endtask

  task automatic test_cfg_pending;
    logic [W-1:0] seq [6];
    logic         rdy [6];
    seq = '{8'd128, 8'd192, 8'd0, 8'd32, 8'd64, 8'd96};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset;
    load_inc(8'd64);
    start_run;
    tick;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL pend_ready_pre got=%b exp=1", cfg_if.cfg_ready); end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = 8'd32;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i == 0) cfg_if.cfg_inc = 8'd16;
      if (i == 1) cfg_if.cfg_valid = 1'b0;
      checks++; if (dut.acc_q !== seq[i]) begin failures++; $display("FAIL pend_acc cyc=%0d got=%0d exp=%0d", i, dut.acc_q, seq[i]); end
      checks++; if (cfg_if.cfg_ready !== rdy[i]) begin failures++; $display("FAIL pend_ready cyc=%0d got=%b exp=%b", i, cfg_if.cfg_ready, rdy[i]); end
    end
  endtask

  task automatic test_drain;
    do_reset;
    load_inc(8'd64);
    start_run;
    tick; tick;
    checks++; if (rtc !== 1'b1) begin failures++; $display("FAIL drain_rtc_hi got=%b exp=1", rtc); end
    en = 1'b0;
    tick;
    checks++; if (dut.acc_q !== 8'd192 || busy !== 1'b1) begin failures++; $display("FAIL drain_mid acc=%0d busy=%b exp acc=192 busy=1", dut.acc_q, busy); end
    tick;
    checks++; if (dut.acc_q !== 8'd0 || rtc !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL drain_end acc=%0d rtc=%b busy=%b exp 0/0/0", dut.acc_q, rtc, busy); end
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++; if (rise !== 1'b0 || dut.acc_q !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL drain_idle cyc=%0d rise=%b acc=%0d busy=%b exp 0/0/0", i, rise, dut.acc_q, busy); end
    end
    checks++; if (tick_cnt !== 8'd1) begin failures++; $display("FAIL drain_cnt got=%0d exp=1", tick_cnt); end
  endtask

  // en drops in the wrap cycle: the wrap is kept and a full period follows.
  task automatic test_drain_at_wrap;
    logic [W-1:0] seq [5];
    logic         bz  [5];
    seq = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0};
    bz  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset;
    load_inc(8'd64);
    start_run;
    tick; tick; tick;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (dut.acc_q !== seq[i] || busy !== bz[i]) begin failures++; $display("FAIL wrapdrain cyc=%0d acc=%0d busy=%b exp acc=%0d busy=%b", i, dut.acc_q, busy, seq[i], bz[i]); end
    end
  endtask

  task automatic test_clamp_and_freeze;
    logic [W-1:0] ea;
    do_reset;
    load_inc(8'd200);
    start_run;
    for (int i = 0; i < 4; i++) begin
      ea = (i % 2 == 0) ? 8'd128 : 8'd0;
      tick;
      checks++; if (dut.acc_q !== ea || rtc !== ea[7]) begin failures++; $display("FAIL clamp cyc=%0d acc=%0d rtc=%b exp acc=%0d", i, dut.acc_q, rtc, ea); end
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = 8'd0;
    tick;
    cfg_if.cfg_valid = 1'b0;
    checks++; if (dut.acc_q !== 8'd128 || cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL freeze_accept acc=%0d ready=%b exp 128/0", dut.acc_q, cfg_if.cfg_ready); end
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (dut.acc_q !== 8'd0 || rtc !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL freeze cyc=%0d acc=%0d rtc=%b busy=%b exp 0/0/1", i, dut.acc_q, rtc, busy); end
    end
  endtask

  task automatic test_reset_mid_run;
    do_reset;
    load_inc(8'd64);
    start_run;
    tick;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = 8'd32;
    tick;
    cfg_if.cfg_valid = 1'b0;
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL midrst_pending got=%b exp=0", cfg_if.cfg_ready); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (dut.acc_q !== 8'd0 || rtc !== 1'b0) begin failures++; $display("FAIL midrst_acc acc=%0d rtc=%b exp 0/0", dut.acc_q, rtc); end
    checks++; if (tick_cnt !== 8'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", tick_cnt); end
    checks++; if (cfg_if.cfg_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_ctl ready=%b busy=%b exp 1/0", cfg_if.cfg_ready, busy); end
    tick;
    checks++; if (dut.acc_q !== 8'd0 || busy !== 1'b1) begin failures++; $display("FAIL midrst_restart acc=%0d busy=%b exp 0/1", dut.acc_q, busy); end
    tick;
    checks++; if (dut.acc_q !== 8'd128) begin failures++; $display("FAIL midrst_default_inc acc=%0d exp=128", dut.acc_q); end
  endtask

  task automatic test_cnt_wrap;
    do_reset;
    start_run;
    repeat (510) tick;
    checks++; if (tick_cnt !== 8'd255) begin failures++; $display("FAIL cntwrap_pre got=%0d exp=255", tick_cnt); end
    tick;
    checks++; if (tick_cnt !== 8'd0 || rise !== 1'b1) begin failures++; $display("FAIL cntwrap cnt=%0d rise=%b exp 0/1", tick_cnt, rise); end
  endtask

  initial begin
    test_reset;
    test_default_inc;
    test_inc64;
    test_inc96;
    test_cfg_pending;
    test_drain;
    test_drain_at_wrap;
    test_clamp_and_freeze;
    test_reset_mid_run;
    test_cnt_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
